// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth datapath types and operand widths
package synth_pkg;

    localparam int MULT_WIDTH     = 16;
    localparam int MULT_FRAC_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

endpackage

// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - shift-add fractional multiplier, product = (multiplicand*scale) >> FRAC_BITS
module sequential_multiplier
    import synth_pkg::*;
#(
    parameter int WIDTH     = MULT_WIDTH,
    parameter int FRAC_BITS = MULT_FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [FRAC_BITS-1:0] scale,
    output logic [WIDTH-1:0]     product,
    output logic                 busy,
    output logic                 done
);

    localparam int ACC_W = WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(FRAC_BITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(FRAC_BITS - 1);

    mult_state_t          r_state;
    mult_state_t          w_state_next;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     w_addend;
    logic [ACC_W-1:0]     w_acc_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [FRAC_BITS-1:0] r_scale;
    logic [WIDTH-1:0]     r_product;
    logic                 r_busy;
    logic                 r_done;

    always_comb begin
        w_state_next = r_state;
        w_addend     = '0;
        w_acc_next   = r_acc;
        case (r_state)
            IDLE: begin
                if (en) w_state_next = CALC;
            end
            CALC: begin
                // LSB-first: bit i of scale contributes multiplicand << i
                if (r_scale[r_cnt]) w_addend = ACC_W'(r_mcand) << r_cnt;
                w_acc_next = r_acc + w_addend;
                if (r_cnt == LAST_ITER) w_state_next = FINISH;
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_scale   <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_mcand <= multiplicand;
                        r_scale <= scale;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                FINISH: begin
                    r_product <= r_acc[ACC_W-1:FRAC_BITS];
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
